// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and default sizing for the hazard scoreboard.
// Holds the register address type, the x0 constant and the scoreboard defaults.
package cpu_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  localparam int SB_MAX_OUTSTANDING = 4;
  localparam int SB_CNT_W           = 2;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/sb_pend_counter.sv
// Saturating up/down counter tracking in-flight long writes to one register.
// inc and dec together cancel; it never wraps past 0 or the all-ones value.
module sb_pend_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CNT_MAX) begin
      count_d = count_q + CNT_ONE;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign sat   = (count_q == CNT_MAX);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight long-latency register writes and stalls ID on unresolved sources.
// Optional macro SB_RETIRE_BYPASS_EN lets a source waiting on its last retire issue in the retire cycle.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = SB_MAX_OUTSTANDING,
  parameter int CNT_W           = SB_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      id_valid,
  input  reg_addr_t id_rs1_addr,
  input  logic      id_rs1_used,
  input  reg_addr_t id_rs2_addr,
  input  logic      id_rs2_used,
  input  reg_addr_t id_rd_addr,
  input  logic      id_long,
  input  logic      ex_mem_read,
  input  reg_addr_t ex_rd_addr,
  input  logic      flush,
  input  logic      wb_valid,
  input  logic      wb_long,
  input  reg_addr_t wb_rd_addr,
  output logic      stall,
  output logic [3:0] outstanding,
  output logic      err_underflow
);

  localparam logic [3:0] TOTAL_MAX = 4'(MAX_OUTSTANDING);
  localparam logic [3:0] TOTAL_ONE = 4'd1;

  logic [CNT_W-1:0] pend [32];
  logic [31:0]      pend_zero;
  logic [31:0]      pend_sat;

  logic [3:0] total_q, total_d;
  logic       err_q, err_d;

  logic issue, retire, wb_long_valid, underflow;
  logic hit1, hit2, loaduse1, loaduse2, structural;
  logic rs1_bypass, rs2_bypass;

  // x0 is hard-wired empty so every lookup can index the array directly.
  assign pend[0]      = '0;
  assign pend_zero[0] = 1'b1;
  assign pend_sat[0]  = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pend
      sb_pend_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (issue && (id_rd_addr == reg_addr_t'(gi))),
        .dec  (retire && (wb_rd_addr == reg_addr_t'(gi))),
        .count(pend[gi]),
        .zero (pend_zero[gi]),
        .sat  (pend_sat[gi])
      );
    end
  endgenerate

  assign wb_long_valid = wb_valid && wb_long && !is_zero_reg(wb_rd_addr);
  assign retire        = wb_long_valid && !pend_zero[wb_rd_addr];
  assign underflow     = wb_long_valid && pend_zero[wb_rd_addr];

`ifdef SB_RETIRE_BYPASS_EN
  localparam logic [CNT_W-1:0] PEND_ONE = 1;
  // The WB forwarding path supplies the value of the last outstanding write.
  assign rs1_bypass = retire && (wb_rd_addr == id_rs1_addr) && (pend[id_rs1_addr] == PEND_ONE);
  assign rs2_bypass = retire && (wb_rd_addr == id_rs2_addr) && (pend[id_rs2_addr] == PEND_ONE);
`else
  assign rs1_bypass = 1'b0;
  assign rs2_bypass = 1'b0;
`endif

  assign hit1 = id_rs1_used && !is_zero_reg(id_rs1_addr) && !pend_zero[id_rs1_addr] && !rs1_bypass;
  assign hit2 = id_rs2_used && !is_zero_reg(id_rs2_addr) && !pend_zero[id_rs2_addr] && !rs2_bypass;

  assign loaduse1 = id_rs1_used && !is_zero_reg(id_rs1_addr) && ex_mem_read && (ex_rd_addr == id_rs1_addr);
  assign loaduse2 = id_rs2_used && !is_zero_reg(id_rs2_addr) && ex_mem_read && (ex_rd_addr == id_rs2_addr);

  assign structural = id_long && ((total_q == TOTAL_MAX) ||
                                  (!is_zero_reg(id_rd_addr) && pend_sat[id_rd_addr]));

  assign stall = rst && id_valid && !flush &&
                 (hit1 || hit2 || loaduse1 || loaduse2 || structural);

  assign issue = id_valid && !stall && !flush && id_long && !is_zero_reg(id_rd_addr);

  always_comb begin
    total_d = total_q;
    err_d   = err_q || underflow;
    case ({issue, retire})
      2'b10:   total_d = total_q + TOTAL_ONE;
      2'b01:   total_d = total_q - TOTAL_ONE;
      default: total_d = total_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign outstanding   = total_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register count model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic       id_rs1_used;
  logic [4:0] id_rs2_addr;
  logic       id_rs2_used;
  logic [4:0] id_rd_addr;
  logic       id_long;
  logic       ex_mem_read;
  logic [4:0] ex_rd_addr;
  logic       flush;
  logic       wb_valid;
  logic       wb_long;
  logic [4:0] wb_rd_addr;
  logic       stall;
  logic [3:0] outstanding;
  logic       err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int MAXO = 4;
  localparam int SATV = 3;

  int pend_m [32];
  int total_m;
  bit err_m;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs2_used  (id_rs2_used),
    .id_rd_addr   (id_rd_addr),
    .id_long      (id_long),
    .ex_mem_read  (ex_mem_read),
    .ex_rd_addr   (ex_rd_addr),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_long      (wb_long),
    .wb_rd_addr   (wb_rd_addr),
    .stall        (stall),
    .outstanding  (outstanding),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic bit src_blocked(input bit used, input int rs);
    if (!used || rs == 0) return 1'b0;
    if (ex_mem_read && ex_rd_addr == rs) return 1'b1;
    if (pend_m[rs] == 0) return 1'b0;
`ifdef SB_RETIRE_BYPASS_EN
    if (pend_m[rs] == 1 && wb_valid && wb_long && wb_rd_addr == rs) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit model_stall();
    if (!rst || !id_valid || flush) return 1'b0;
    if (src_blocked(id_rs1_used, int'(id_rs1_addr))) return 1'b1;
    if (src_blocked(id_rs2_used, int'(id_rs2_addr))) return 1'b1;
    if (id_long && (total_m == MAXO || (id_rd_addr != 0 && pend_m[id_rd_addr] == SATV))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input bit st);
    bit iss, wbl, ret;
    if (!rst) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
      total_m = 0;
      err_m   = 1'b0;
      return;
    end
    iss = id_valid && !st && !flush && id_long && id_rd_addr != 0;
    wbl = wb_valid && wb_long && wb_rd_addr != 0;
    ret = wbl && pend_m[wb_rd_addr] > 0;
    if (wbl && !ret) err_m = 1'b1;
    if (ret) pend_m[wb_rd_addr] -= 1;
    if (iss) pend_m[id_rd_addr] += 1;
    total_m = total_m + int'(iss) - int'(ret);
  endtask

  // Advance one cycle: sample stall at the falling edge, move the model with the edge.
  task automatic step(output logic obs_stall, output logic exp_stall);
    @(negedge clk);
    obs_stall = stall;
    exp_stall = model_stall();
    model_update(exp_stall);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; id_valid = 1'b0; id_rs1_addr = 0; id_rs1_used = 1'b0;
    id_rs2_addr = 0; id_rs2_used = 1'b0; id_rd_addr = 0; id_long = 1'b0;
    ex_mem_read = 1'b0; ex_rd_addr = 0; flush = 1'b0;
    wb_valid = 1'b0; wb_long = 1'b0; wb_rd_addr = 0;
  endtask

  task automatic set_id(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit lng);
    id_valid = v; id_rs1_addr = 5'(r1); id_rs1_used = u1;
    id_rs2_addr = 5'(r2); id_rs2_used = u2; id_rd_addr = 5'(rd); id_long = lng;
  endtask

  task automatic set_wb(input bit v, input int rd);
    wb_valid = v; wb_long = v; wb_rd_addr = 5'(rd);
  endtask

  task automatic test_reset();
    logic o, e;
    idle();
    rst = 1'b0;
    set_id(1, 5, 1, 0, 0, 5, 1);
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
    for (int c = 0; c < 3; c++) begin
      step(o, e);
      n_checks++;
      if (o !== 1'b0) begin n_fail++; $display("FAIL reset_stall cyc=%0d got=%b want=0", c, o); end
      n_checks++;
      if (outstanding !== 4'd0 || err_underflow !== 1'b0) begin
        n_fail++; $display("FAIL reset_state cyc=%0d outstanding=%0d err=%b want 0/0", c, outstanding, err_underflow);
      end
    end
    idle();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    logic o, e;
    idle();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd7;
    set_id(1, 7, 1, 0, 0, 10, 0);
    step(o, e);
    n_checks++;
    if (o !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%b want=1", o); end
    ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
    step(o, e);
    n_checks++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL load_use_release got=%b want=0", o); end
    idle();
    $display("test_load_use done");
  endtask

  task automatic test_long_producer();
    logic o, e;
    logic want_retire_stall;
`ifdef SB_RETIRE_BYPASS_EN
    want_retire_stall = 1'b0;
`else
    want_retire_stall = 1'b1;
`endif
    idle();
    set_id(1, 0, 0, 0, 0, 3, 1);
    step(o, e);
    n_checks++;
    if (o !== 1'b0 || outstanding !== 4'd1) begin
      n_fail++; $display("FAIL long_issue stall=%b outstanding=%0d want 0/1", o, outstanding);
    end
    set_id(1, 0, 0, 3, 1, 11, 0);
    for (int c = 0; c < 3; c++) begin
      step(o, e);
      n_checks++;
      if (o !== 1'b1) begin n_fail++; $display("FAIL long_wait cyc=%0d got=%b want=1", c, o); end
    end
    set_wb(1, 3);
    step(o, e);
    n_checks++;
    if (o !== want_retire_stall || outstanding !== 4'd0) begin
      n_fail++; $display("FAIL long_retire stall=%b outstanding=%0d want %b/0", o, outstanding, want_retire_stall);
    end
    set_wb(0, 0);
    step(o, e);
    n_checks++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL long_after_retire got=%b want=0", o); end
    idle();
    $display("test_long_producer done");
  endtask

  task automatic test_capacity();
    logic o, e;
    idle();
    for (int r = 1; r <= 4; r++) begin
      set_id(1, 0, 0, 0, 0, r, 1);
      step(o, e);
    end
    n_checks++;
    if (outstanding !== 4'd4) begin n_fail++; $display("FAIL cap_fill outstanding=%0d want=4", outstanding); end
    set_id(1, 0, 0, 0, 0, 9, 1);
    step(o, e);
    n_checks++;
    if (o !== 1'b1 || outstanding !== 4'd4) begin
      n_fail++; $display("FAIL cap_full stall=%b outstanding=%0d want 1/4", o, outstanding);
    end
    set_wb(1, 1);
    step(o, e);
    n_checks++;
    if (o !== 1'b1 || outstanding !== 4'd3) begin
      n_fail++; $display("FAIL cap_retire stall=%b outstanding=%0d want 1/3", o, outstanding);
    end
    set_wb(0, 0);
    step(o, e);
    n_checks++;
    if (o !== 1'b0 || outstanding !== 4'd4) begin
      n_fail++; $display("FAIL cap_reissue stall=%b outstanding=%0d want 0/4", o, outstanding);
    end
    idle();
    for (int r = 2; r <= 5; r++) begin
      set_wb(1, (r == 5) ? 9 : r);
      step(o, e);
    end
    n_checks++;
    if (outstanding !== 4'd0 || err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL cap_drain outstanding=%0d err=%b want 0/0", outstanding, err_underflow);
    end
    idle();
    $display("test_capacity done");
  endtask

  task automatic test_simultaneous_flush();
    logic o, e;
    idle();
    set_id(1, 0, 0, 0, 0, 6, 1);
    step(o, e);
    set_wb(1, 6);
    step(o, e);
    n_checks++;
    if (o !== 1'b0 || outstanding !== 4'd1) begin
      n_fail++; $display("FAIL simul_issue_retire stall=%b outstanding=%0d want 0/1", o, outstanding);
    end
    set_wb(0, 0);
    set_id(1, 6, 1, 0, 0, 13, 0);
    step(o, e);
    n_checks++;
    if (o !== 1'b1) begin n_fail++; $display("FAIL simul_pend_kept got=%b want=1", o); end
    flush = 1'b1;
    step(o, e);
    n_checks++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL flush_hit_stall got=%b want=0", o); end
    set_id(1, 0, 0, 0, 0, 8, 1);
    step(o, e);
    n_checks++;
    if (o !== 1'b0 || outstanding !== 4'd1) begin
      n_fail++; $display("FAIL flush_long stall=%b outstanding=%0d want 0/1", o, outstanding);
    end
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 6);
    step(o, e);
    n_checks++;
    if (outstanding !== 4'd0 || err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_drain outstanding=%0d err=%b want 0/0", outstanding, err_underflow);
    end
    idle();
    $display("test_simultaneous_flush done");
  endtask

  task automatic test_x0_underflow();
    logic o, e;
    idle();
    set_id(1, 0, 0, 0, 0, 0, 1);
    step(o, e);
    n_checks++;
    if (o !== 1'b0 || outstanding !== 4'd0) begin
      n_fail++; $display("FAIL x0_issue stall=%b outstanding=%0d want 0/0", o, outstanding);
    end
    set_id(1, 0, 1, 0, 1, 0, 0);
    step(o, e);
    n_checks++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL x0_read got=%b want=0", o); end
    idle();
    set_wb(1, 12);
    step(o, e);
    n_checks++;
    if (err_underflow !== 1'b1 || outstanding !== 4'd0) begin
      n_fail++; $display("FAIL underflow_set err=%b outstanding=%0d want 1/0", err_underflow, outstanding);
    end
    idle();
    for (int c = 0; c < 3; c++) step(o, e);
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got=%b want=1", err_underflow); end
    $display("test_x0_underflow done");
  endtask

  task automatic test_random();
    logic o, e;
    int r;
    idle();
    rst = 1'b0;
    step(o, e);
    idle();
    n_checks++;
    if (err_underflow !== 1'b0 || outstanding !== 4'd0) begin
      n_fail++; $display("FAIL rand_reset err=%b outstanding=%0d want 0/0", err_underflow, outstanding);
    end
    for (int c = 0; c < 600; c++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 2) == 0);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd_addr  = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 7) == 0);
      // Mostly retire something actually pending so the counts keep moving.
      r = $urandom_range(0, 7);
      for (int k = 1; k < 8; k++) if (pend_m[k] > 0 && $urandom_range(0, 1) == 1) r = k;
      set_wb($urandom_range(0, 1) == 1, r);
      wb_long = wb_valid && ($urandom_range(0, 7) != 0);
      step(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rand_stall cyc=%0d got=%b want=%b", c, o, e); end
      n_checks++;
      if (outstanding !== 4'(total_m) || err_underflow !== err_m) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d outstanding=%0d err=%b want %0d/%b", c, outstanding, err_underflow, total_m, err_m);
      end
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    idle();
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
    total_m = 0;
    err_m   = 1'b0;
    test_reset();
    test_load_use();
    test_long_producer();
    test_capacity();
    test_simultaneous_flush();
    test_x0_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
